// File: rtl/cobs_packet_arbiter_pkg.sv
// cobs_packet_arbiter_pkg: shared state type and constants for the COBS packet arbiter
package cobs_arb_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    ABORT   = 3'd3,
    DRAIN   = 3'd4
  } state_t;
  localparam int HEADER_W = 8;
  localparam logic [7:0] ABORT_FILL_BYTE = 8'h00;
  localparam int TIMEOUT_CNT_W = 16;
endpackage

// File: rtl/cobs_packet_arbiter_if.sv
// cobs_packet_arbiter_if: 8-bit AXI-stream link from the arbiter into the COBS encoder
interface axis_interface;
  import cobs_arb_pkg::*;
  logic [HEADER_W-1:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  logic tuser;
  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/cobs_packet_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after last_ptr
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_ptr,
  output logic [W-1:0] winner,
  output logic any_req
);
  logic [W-1:0] idx;
  assign any_req = |req;
  // scan from farthest to nearest so the nearest requester after last_ptr wins
  always_comb begin
    winner = last_ptr;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(last_ptr) + k) % N);
      if (req[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/cobs_packet_arbiter.sv
// cobs_packet_arbiter: per-packet round-robin mux with source-ID header feeding a COBS encoder; ARB_TIMEOUT_EN adds mid-packet abort/drain
module cobs_packet_arbiter
  import cobs_arb_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int GW = $clog2(NUM_SOURCES)
) (
  input  logic clk,
  input  logic reset,
  input  logic [8*NUM_SOURCES-1:0] s_tdata,
  input  logic [NUM_SOURCES-1:0] s_tvalid,
  output logic [NUM_SOURCES-1:0] s_tready,
  input  logic [NUM_SOURCES-1:0] s_tlast,
  input  logic [NUM_SOURCES-1:0] s_tuser,
  axis_interface.master encoded_src,
  output logic [GW-1:0] grant_id,
  output logic busy
);
  state_t state;
  logic [GW-1:0] rr_ptr, winner;
  logic any_req, g_valid, g_last, g_user, xfer, timed_out;
  logic in_hdr, in_pay, in_abt, in_drn;
  logic [7:0] g_data;
  if (NUM_SOURCES < 2 || NUM_SOURCES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2 ** TIMEOUT_CNT_W) begin : g_bad_param
    $error("cobs_packet_arbiter: parameter out of range");
  end
  rr_arbiter #(.N(NUM_SOURCES)) u_rr (
    .req(s_tvalid),
    .last_ptr(rr_ptr),
    .winner(winner),
    .any_req(any_req)
  );
  assign g_valid = s_tvalid[grant_id];
  assign g_last = s_tlast[grant_id];
  assign g_user = s_tuser[grant_id];
  assign g_data = s_tdata[8*grant_id +: 8];
  assign in_hdr = state == HEADER;
  assign in_pay = state == PAYLOAD;
`ifdef ARB_TIMEOUT_EN
  logic [TIMEOUT_CNT_W-1:0] idle_cnt;
  assign in_abt = state == ABORT;
  assign in_drn = state == DRAIN;
  assign timed_out = !g_valid && idle_cnt == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);
  // count consecutive payload cycles the granted source sits idle; a stalled beat is not idle
  always_ff @(posedge clk) idle_cnt <= (reset || !in_pay || xfer) ? '0 : !g_valid ? idle_cnt + 1'b1 : idle_cnt;
`else
  assign in_abt = 1'b0;
  assign in_drn = 1'b0;
  assign timed_out = 1'b0;
`endif
  assign encoded_src.tvalid = in_hdr | in_abt | (in_pay & g_valid);
  assign encoded_src.tdata = in_hdr ? HEADER_W'(grant_id) : in_pay ? g_data : in_abt ? ABORT_FILL_BYTE : '0;
  assign encoded_src.tlast = in_abt | (in_pay & g_last);
  assign encoded_src.tuser = in_abt | (in_pay & g_user);
  assign s_tready = (in_drn | (in_pay & encoded_src.tready)) ? NUM_SOURCES'(1) << grant_id : '0;
  assign xfer = encoded_src.tvalid & encoded_src.tready;
  assign busy = state != IDLE;
  // packet FSM; the grant is latched in IDLE and held until the packet (or its drain) completes
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= GW'(NUM_SOURCES - 1);
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant_id <= winner;
          rr_ptr <= winner;
          state <= HEADER;
        end
        HEADER: if (encoded_src.tready) state <= PAYLOAD;
        PAYLOAD: if (xfer && g_last) state <= IDLE; else if (timed_out) state <= ABORT;
`ifdef ARB_TIMEOUT_EN
        ABORT: if (encoded_src.tready) state <= DRAIN;
        DRAIN: if (g_valid && g_last) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule
